// File: rtl/rom_boot_loader.sv
// Frames a UART byte stream (0xA5, LEN_LO, LEN_HI, LEN words LSB first) into ROM word writes,
// holding the core in reset while loading. Define ROM_LOADER_CHECKSUM_EN for a trailing checksum.
module rom_boot_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        w_en_o,
  output logic [31:0] w_addr_o,
  output logic [31:0] w_data_o,
  output logic [3:0]  w_sel_o,
  output logic        hold_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] words_o
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSync  = 3'd1;
  localparam logic [2:0] StLenLo = 3'd2;
  localparam logic [2:0] StLenHi = 3'd3;
  localparam logic [2:0] StData  = 3'd4;
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam logic [2:0] StCsum  = 3'd5;
`endif
  localparam logic [2:0] StDone  = 3'd6;
  localparam logic [2:0] StErr   = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       words_q, words_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              w_en_q, w_en_d;
  logic [31:0]       w_addr_q, w_addr_d;
  logic [31:0]       w_data_q, w_data_d;
  logic [15:0]       len_rx;
  logic              timed;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  assign len_rx = {rx_data_i, len_q[7:0]};

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    words_d  = words_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    timer_d  = timer_q;
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
    timed    = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData) ||
               (state_q == StCsum);
`else
    timed    = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
`endif

    if (timed) begin
      timer_d = rx_valid_i ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start_i) state_d = StSync;
      end
      StSync: begin
        if (rx_valid_i && rx_data_i == 8'hA5) state_d = StLenLo;
      end
      StLenLo: begin
        if (rx_valid_i) begin
          len_d   = {8'h00, rx_data_i};
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (rx_valid_i) begin
          len_d = len_rx;
          if (len_rx == 16'd0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StDone;
`endif
          end else if (32'(len_rx) > MAX_WORDS) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (words_q == len_q) begin
          // Last write is on the port this cycle; leave DATA so hold drops one cycle later.
`ifdef ROM_LOADER_CHECKSUM_EN
          if (rx_valid_i) begin
            state_d = (sum_q + rx_data_i == 8'h00) ? StDone : StErr;
          end else begin
            state_d = StCsum;
          end
`else
          state_d = StDone;
`endif
        end else if (rx_valid_i) begin
          idx_d = idx_q + 2'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
          sum_d = sum_q + rx_data_i;
`endif
          case (idx_q)
            2'd0: asm_d[7:0]   = rx_data_i;
            2'd1: asm_d[15:8]  = rx_data_i;
            2'd2: asm_d[23:16] = rx_data_i;
            default: begin
              w_en_d   = 1'b1;
              w_addr_d = BASE_ADDR + {14'd0, words_q, 2'b00};
              w_data_d = {rx_data_i, asm_q};
              words_d  = words_q + 16'd1;
            end
          endcase
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      StCsum: begin
        if (rx_valid_i) state_d = (sum_q + rx_data_i == 8'h00) ? StDone : StErr;
      end
`endif
      StDone, StErr: begin
        if (start_i) begin
          state_d = StSync;
          len_d   = '0;
          words_d = '0;
          idx_d   = '0;
          asm_d   = '0;
          timer_d = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    // A byte in the same cycle as expiry wins.
    if (timed && !rx_valid_i && timer_q == TimerLast) state_d = StErr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      words_q  <= '0;
      idx_q    <= '0;
      asm_q    <= '0;
      timer_q  <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      words_q  <= words_d;
      idx_q    <= idx_d;
      asm_q    <= asm_d;
      timer_q  <= timer_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign w_en_o   = w_en_q;
  assign w_addr_o = w_addr_q;
  assign w_data_o = w_data_q;
  assign w_sel_o  = w_en_q ? 4'b1111 : 4'b0000;
  assign hold_o   = ((state_q != StIdle) && (state_q != StDone)) || w_en_q;
  assign done_o   = (state_q == StDone);
  assign err_o    = (state_q == StErr);
  assign words_o  = words_q;

endmodule
